// File: rtl/decimal_to_bcd_entry_if.sv
// Keypad-side and consumer-side signals of the decimal-to-BCD entry block.
// The slave modport is the entry block; the master modport is whoever drives the keys and consumes numbers.
interface decimal_to_bcd_entry_if #(
  parameter int DIGITS = 4
);
  localparam int CW = $clog2(DIGITS + 1);

  logic [9:0]          key;
  logic                enter;
  logic                clr;
  logic                key_valid;
  logic [3:0]          key_code;
  logic                err;
  logic [4*DIGITS-1:0] bcd_acc;
  logic [CW-1:0]       digit_count;
  logic [4*DIGITS-1:0] num_out;
  logic [CW-1:0]       num_count;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output key, enter, clr, out_ready,
    input  key_valid, key_code, err, bcd_acc, digit_count, num_out, num_count, out_valid
  );

  modport slave (
    input  key, enter, clr, out_ready,
    output key_valid, key_code, err, bcd_acc, digit_count, num_out, num_count, out_valid
  );
endinterface

// File: rtl/decimal_to_bcd_entry.sv
// Debounced 10-line decimal key encoder feeding a shifting BCD accumulator; a digit lands
// DEBOUNCE_CYCLES+1 edges after the key is first sampled; commits are held until the consumer takes them.
module decimal_to_bcd_entry #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  decimal_to_bcd_entry_if.slave  bus
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int DW = 4 * DIGITS;
  localparam int NW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_RELEASE} state_t;

  state_t          r_state;
  logic [9:0]      r_sync;
  logic [9:0]      r_key_s;
  logic [9:0]      r_cand;
  logic [NW-1:0]   r_cnt;
  logic            r_key_valid;
  logic [3:0]      r_key_code;
  logic            r_err;
  logic [DW-1:0]   r_acc;
  logic [CW-1:0]   r_count;
  logic [DW-1:0]   r_num;
  logic [CW-1:0]   r_num_count;
  logic            r_out_valid;

  state_t          w_state_nxt;
  logic [9:0]      w_cand_nxt;
  logic [9:0]      w_hit;
  logic [NW-1:0]   w_cnt_nxt;
  logic            w_accept;
  logic            w_multi;
  logic            w_onehot;
  logic [3:0]      w_code;
  logic            w_commit;
  logic [DW-1:0]   w_base_acc;
  logic [CW-1:0]   w_base_count;
  logic [DW-1:0]   w_acc_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic            w_overflow;

  assign w_onehot = (r_key_s != '0) && ((r_key_s & (r_key_s - 10'd1)) == '0);

  // The counter tracks stable samples already seen; the last one of the run is the deciding edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_multi     = 1'b0;
    w_hit       = r_cand;
    case (r_state)
      S_IDLE: begin
        if (w_onehot) begin
          w_cand_nxt = r_key_s;
          w_hit      = r_key_s;
          if (DEBOUNCE_CYCLES == 1) begin
            w_accept    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_RELEASE;
          end else begin
            w_cnt_nxt   = NW'(1);
            w_state_nxt = S_DEBOUNCE;
          end
        end else if (r_key_s != '0) begin
          w_multi     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RELEASE;
        end
      end
      S_DEBOUNCE: begin
        if (r_key_s != r_cand) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == NW'(DEBOUNCE_CYCLES - 1)) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + NW'(1);
        end
      end
      S_RELEASE: begin
        if (r_key_s != '0) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == NW'(DEBOUNCE_CYCLES - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + NW'(1);
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_code = '0;
    for (int i = 0; i < 10; i++) begin
      if (w_hit[i]) w_code = 4'(i);
    end
  end

  // A commit empties the accumulator first, so a digit accepted on the same edge starts the next number.
  assign w_commit     = bus.enter && !r_out_valid;
  assign w_base_acc   = w_commit ? '0 : r_acc;
  assign w_base_count = w_commit ? '0 : r_count;

  always_comb begin
    w_acc_nxt   = w_base_acc;
    w_count_nxt = w_base_count;
    w_overflow  = 1'b0;
    if (bus.clr) begin
      w_acc_nxt   = '0;
      w_count_nxt = '0;
    end else if (w_accept) begin
      if (w_base_count < CW'(DIGITS)) begin
        w_acc_nxt      = w_base_acc << 4;
        w_acc_nxt[3:0] = w_code;
        w_count_nxt    = w_base_count + CW'(1);
      end else begin
        w_overflow = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sync  <= '0;
      r_key_s <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= bus.key;
      r_key_s <= r_sync;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_err       <= 1'b0;
      r_acc       <= '0;
      r_count     <= '0;
      r_num       <= '0;
      r_num_count <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= w_code;
      r_err   <= w_multi || w_overflow;
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      if (w_commit) begin
        r_num       <= r_acc;
        r_num_count <= r_count;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.key_valid   = r_key_valid;
  assign bus.key_code    = r_key_code;
  assign bus.err         = r_err;
  assign bus.bcd_acc     = r_acc;
  assign bus.digit_count = r_count;
  assign bus.num_out     = r_num;
  assign bus.num_count   = r_num_count;
  assign bus.out_valid   = r_out_valid;
endmodule

// File: tb/tb_decimal_to_bcd_entry.sv
// Directed and randomised key/enter/clr/ready traffic against a digit-queue model of the entry block.
module tb_decimal_to_bcd_entry;
  localparam int DIGITS = 4;
  localparam int DC     = 4;

  logic clk;
  logic rst;

  decimal_to_bcd_entry_if #(.DIGITS(DIGITS)) bus ();

  decimal_to_bcd_entry #(.DIGITS(DIGITS), .DEBOUNCE_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int          dq[$];
  bit          m_ov = 1'b0;
  logic [31:0] exp_num  = '0;
  int          exp_ncnt = 0;

  int          kv_cnt, err_cnt, first_kv, tick_no;
  logic [3:0]  last_code;

  function automatic logic [31:0] m_acc();
    logic [31:0] v = '0;
    foreach (dq[i]) v = (v << 4) | 32'(dq[i]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    kv_cnt = 0; err_cnt = 0; first_kv = -1; tick_no = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tick_no++;
    if (bus.key_valid) begin
      kv_cnt++;
      last_code = bus.key_code;
      if (first_kv < 0) first_kv = tick_no;
    end
    if (bus.err) err_cnt++;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".bcd_acc"},     32'(bus.bcd_acc),     m_acc());
    check({tag, ".digit_count"}, 32'(bus.digit_count), 32'(dq.size()));
    check({tag, ".out_valid"},   32'(bus.out_valid),   32'(m_ov));
    if (m_ov) begin
      check({tag, ".num_out"},   32'(bus.num_out),   exp_num);
      check({tag, ".num_count"}, 32'(bus.num_count), 32'(exp_ncnt));
    end
  endtask

  // side: 0 none, 1 enter on the accept edge, 2 clr on the accept edge
  task automatic press(input int d, input int hold, input int side);
    logic [31:0] old_acc = m_acc();
    int          old_n   = dq.size();
    bit          acc_ok  = (hold >= DC);
    int          exp_err = 0;
    mon_clear();
    bus.key = 10'b1 << d;
    for (int t = 1; t <= hold + DC + 4; t++) begin
      if (t == hold + 1) bus.key = '0;
      if (side == 1 && t == DC + 2) bus.enter = 1'b1;
      if (side == 2 && t == DC + 2) bus.clr = 1'b1;
      tick();
      bus.enter = 1'b0;
      bus.clr   = 1'b0;
    end
    if (acc_ok) begin
      check("press.kv_pulses",  32'(kv_cnt),   32'd1);
      check("press.kv_latency", 32'(first_kv), 32'(DC + 2));
      check("press.key_code",   32'(last_code), 32'(d));
      if (side == 1) begin
        exp_num = old_acc; exp_ncnt = old_n; m_ov = 1'b1;
        dq.delete(); dq.push_back(d);
      end else if (side == 2) begin
        dq.delete();
      end else if (dq.size() < DIGITS) begin
        dq.push_back(d);
      end else begin
        exp_err = 1;
      end
    end else begin
      check("bounce.kv_pulses", 32'(kv_cnt), 32'd0);
    end
    check("press.err_pulses", 32'(err_cnt), 32'(exp_err));
    check_state("press");
  endtask

  task automatic do_enter();
    mon_clear();
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    if (!m_ov) begin
      exp_num = m_acc(); exp_ncnt = dq.size(); m_ov = 1'b1;
      dq.delete();
    end
    check_state("enter");
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    m_ov = 1'b0;
    check_state("drain");
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    dq.delete();
    check_state("clr");
  endtask

  initial begin
    int hold, d, side;
    bus.key = '0; bus.enter = 1'b0; bus.clr = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst.key_valid",   32'(bus.key_valid),   32'd0);
    check("rst.key_code",    32'(bus.key_code),    32'd0);
    check("rst.err",         32'(bus.err),         32'd0);
    check("rst.num_out",     32'(bus.num_out),     32'd0);
    check("rst.num_count",   32'(bus.num_count),   32'd0);
    check_state("rst");
    rst = 1'b0;
    tick();

    press(7, 10, 0);
    check("key7.bcd_acc", 32'(bus.bcd_acc), 32'h0007);
    press(3, 2, 0);
    do_clr();

    press(1, DC + 2, 0); press(9, DC, 0); press(0, DC + 3, 0); press(5, DC + 1, 0);
    check("full.bcd_acc", 32'(bus.bcd_acc), 32'h1905);
    press(6, DC + 2, 0);
    check("overflow.bcd_acc", 32'(bus.bcd_acc), 32'h1905);

    // two keys, then one key still held: only a single err and no digit
    mon_clear();
    bus.key = 10'h014;
    repeat (3) tick();
    bus.key = 10'h004;
    repeat (6) tick();
    bus.key = '0;
    repeat (DC + 4) tick();
    check("multi.err_pulses", 32'(err_cnt), 32'd1);
    check("multi.kv_pulses",  32'(kv_cnt),  32'd0);
    check_state("multi");

    do_clr();
    press(4, DC, 0); press(2, DC, 0);
    do_enter();
    check("commit42.num_out", 32'(bus.num_out), 32'h0042);
    repeat (3) begin
      tick();
      check_state("hold");
    end
    press(5, DC, 0);
    do_enter();
    check("enter_ignored.bcd_acc", 32'(bus.bcd_acc), 32'h0005);
    drain();
    drain();

    do_clr();
    press(1, DC, 0); press(2, DC, 0);
    press(8, DC + 1, 1);
    check("acc_enter.num_out", 32'(bus.num_out), 32'h0012);
    check("acc_enter.bcd_acc", 32'(bus.bcd_acc), 32'h0008);
    drain();
    do_clr();
    press(1, DC, 0); press(2, DC, 0);
    press(8, DC + 1, 2);
    check("acc_clr.key_code", 32'(bus.key_code), 32'd8);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0, 1, 2, 3: begin
          d    = $urandom_range(0, 9);
          hold = $urandom_range(1, DC + 6);
          side = 0;
          if (hold >= DC && $urandom_range(0, 3) == 0) side = (m_ov || $urandom_range(0, 1) == 0) ? 2 : 1;
          press(d, hold, side);
        end
        4: do_enter();
        5: drain();
        default: do_clr();
      endcase
    end

    if (!m_ov) do_enter();
    press(3, DC + 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dq.delete();
    m_ov = 1'b0;
    check("rst_mid.num_out", 32'(bus.num_out), 32'd0);
    check_state("rst_mid");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/decimal_to_bcd_entry.md
Name: decimal_to_bcd_entry

Overview:
- Encodes a 10-line decimal key interface (one line per digit 0-9, as from a keypad or the decimal decode bus) back into 4-bit BCD.
- Synchronises and debounces the key lines, then rejects multi-key presses.
- Shifts accepted digits into a multi-digit BCD accumulator.
- On `enter`, hands the completed number to a downstream consumer over a valid/ready handshake.

Parameters:
- DIGITS, 4, number of BCD digits held in the accumulator and output (min 1).
- DEBOUNCE_CYCLES, 4, consecutive identical samples required to accept a press or a release (min 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- key  input  10  decimal key lines, bit n = digit n; asynchronous to clk.
- enter  input  1  synchronous, clean; commit accumulator.
- clr  input  1  synchronous, clean; clear accumulator.
- key_valid  output  1  one-cycle pulse when a digit is accepted.
- key_code  output  4  BCD code of the last accepted digit.
- err  output  1  one-cycle pulse on multi-key press or digit overflow.
- bcd_acc  output  4*DIGITS  accumulator; least significant digit in [3:0].
- digit_count  output  $clog2(DIGITS+1)  digits currently in the accumulator.
- num_out  output  4*DIGITS  committed number.
- num_count  output  $clog2(DIGITS+1)  digit count of the committed number.
- out_valid  output  1  num_out/num_count valid.
- out_ready  input  1  consumer accepts num_out.

Behaviour:
- Reset (sync, rst=1): all outputs 0, FSM in IDLE, sync flops 0, debounce counter 0.
- Synchroniser: key passes through 2 flops to give key_s. The FSM acts only on key_s.
- FSM states and transitions:
  - IDLE:
    - key_s one-hot: latch the candidate, cnt=1, go to DEBOUNCE.
    - key_s has 2 or more bits set: err pulses, go to RELEASE.
    - key_s == 0: stay.
  - DEBOUNCE:
    - key_s != candidate: go to IDLE, no output.
    - Otherwise cnt++. When the candidate has been seen on DEBOUNCE_CYCLES consecutive edges, accept and go to RELEASE.
  - RELEASE:
    - Requires key_s == 0 on DEBOUNCE_CYCLES consecutive edges, then go to IDLE.
    - Any nonzero sample restarts the count.
    - Held keys and added keys never produce further digits.
- Accept action (registered):
  - key_valid=1 for exactly one cycle.
  - key_code = binary index of the candidate.
  - If digit_count < DIGITS: bcd_acc <= {bcd_acc[4*DIGITS-5:0], key_code} and digit_count++.
  - If digit_count == DIGITS: the digit is dropped, err pulses, bcd_acc is unchanged. key_valid still pulses.
- Latency: key stable from edge k gives key_valid and the updated bcd_acc registered at edge k+1+DEBOUNCE_CYCLES. Default: 5 cycles.
- Commit:
  - Condition: enter=1 and out_valid=0.
  - num_out <= bcd_acc (pre-shift value); num_count <= digit_count; out_valid <= 1.
  - bcd_acc, digit_count <= 0.
  - Committing with digit_count=0 is legal and gives num_out=0, num_count=0.
- Enter while out_valid=1: ignored entirely. The accumulator is not cleared.
- Handshake:
  - num_out/num_count are held stable while out_valid=1.
  - A transfer occurs on an edge with out_valid && out_ready, after which out_valid=0.
  - out_ready while out_valid=0 has no effect.
  - A commit in the cycle after a transfer is allowed.
- Simultaneous events:
  - Accept and commit in the same cycle: num_out takes the old accumulator. The new digit becomes the only digit of the cleared accumulator (digit_count=1).
  - Accept and clr: clr wins. Accumulator = 0, count = 0. key_valid/key_code still update.
  - clr and commit: the commit captures the old value, then the accumulator clears.
  - clr never affects out_valid, num_out or num_count.
- Reset mid-debounce or mid-handshake: all state clears the next edge. A pending out_valid is lost.

Test Plan:
- Press key[7] for 10 cycles, then release, DEBOUNCE_CYCLES=4 -> key_valid pulses once 5 cycles after the first sample; key_code=7; bcd_acc=16'h0007; digit_count=1; no second pulse while held.
- Pulse key[3] for 2 cycles only (bounce) -> no key_valid, bcd_acc unchanged, FSM back in IDLE.
- Enter digits 1,9,0,5, then press 6 -> bcd_acc=16'h1905, digit_count=4; the 6 pulses key_valid and err, bcd_acc stays 16'h1905.
- Press key[2] and key[4] together -> err pulses once, no key_valid, no digit accepted until all keys have been released for 4 cycles.
- Accumulator 16'h0042: enter with out_ready=0 for 3 cycles -> out_valid=1, num_out=16'h0042, num_count=2, stable; bcd_acc=0. A second enter is ignored. out_ready=1 -> out_valid=0 the next cycle.
- Accept digit 8 in the same cycle as enter with accumulator 16'h0012 -> num_out=16'h0012, bcd_acc=16'h0008, digit_count=1. Repeat with clr in place of enter -> bcd_acc=0, key_code=8.
